// File: rtl/screen_transition_detector_if.sv
// Sprite position / screen-crossing bus between the game logic and the
// screen transition detector.
interface screen_transition_detector_if;
  logic        frame_clk;
  logic [9:0]  ball_y;
  logic [9:0]  ball_size;
  logic [10:0] background_number;
  logic        ts_collide;
  logic        bs_collide;
  logic        y_reload;
  logic [9:0]  y_reload_value;
  logic        busy;

  // Game side: drives sprite state, receives crossing events
  modport master (
    output frame_clk, ball_y, ball_size, background_number,
    input  ts_collide, bs_collide, y_reload, y_reload_value, busy
  );

  // Detector side
  modport slave (
    input  frame_clk, ball_y, ball_size, background_number,
    output ts_collide, bs_collide, y_reload, y_reload_value, busy
  );
endinterface

// File: rtl/screen_transition_detector.sv
// Detects the sprite leaving the playfield through the top or bottom edge
// once per frame, emits a one-cycle crossing pulse with the re-entry row,
// then holds off until the new screen has settled.
module screen_transition_detector #(
  parameter int unsigned SCREEN_TOP    = 0,
  parameter int unsigned SCREEN_BOTTOM = 479,
  parameter int unsigned ENTRY_MARGIN  = 8,
  parameter int unsigned SETTLE_FRAMES = 4
) (
  input logic                          CLK,
  input logic                          reset,
  screen_transition_detector_if.slave  bus
);

  localparam int unsigned YW = 10;
  localparam int unsigned HW = 11;
  localparam int unsigned SW = 12;
  localparam int unsigned CW = 4;

  localparam logic [HW-1:0] TOP_H       = HW'(SCREEN_TOP);
  localparam logic [HW-1:0] BOT_H       = HW'(SCREEN_BOTTOM);
  localparam logic [SW-1:0] TOP_S       = SW'(SCREEN_TOP);
  localparam logic [SW-1:0] BOT_S       = SW'(SCREEN_BOTTOM);
  localparam logic [SW-1:0] MARGIN_S    = SW'(ENTRY_MARGIN);
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_FRAMES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TOP_HIT = 2'd1,
    BOT_HIT = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  state_t        state;
  logic          frame_q;
  logic [CW-1:0] settle_cnt;

  logic          frame_rise;
  logic [HW-1:0] y_h;
  logic [HW-1:0] size_h;
  logic          top_hit;
  logic          bot_hit;
  logic          active;
  logic          bs_allowed;
  logic [SW-1:0] size_s;
  logic [SW-1:0] reach;
  logic [SW-1:0] top_entry;
  logic [SW-1:0] bot_entry;

  assign frame_rise = bus.frame_clk & ~frame_q;

  // Hit zones in 11-bit arithmetic so the sums cannot wrap
  assign y_h     = {1'b0, bus.ball_y};
  assign size_h  = {1'b0, bus.ball_size};
  assign top_hit = (y_h <= (TOP_H + size_h));
  assign bot_hit = ((y_h + size_h) >= BOT_H);

  // Only the playable screens detect; Green1 has no screen below it
  assign active     = |bus.background_number[8:1];
  assign bs_allowed = active & ~bus.background_number[1];

  // Re-entry rows clamped to the visible range; both share one sum
  assign size_s    = SW'(bus.ball_size);
  assign reach     = TOP_S + size_s + MARGIN_S;
  assign top_entry = (reach >= BOT_S) ? TOP_S : (BOT_S - size_s - MARGIN_S);
  assign bot_entry = (reach > BOT_S)  ? BOT_S : reach;

  // Crossing FSM with registered pulse, reload and busy outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      frame_q            <= 1'b0;
      settle_cnt         <= '0;
      bus.ts_collide     <= 1'b0;
      bus.bs_collide     <= 1'b0;
      bus.y_reload       <= 1'b0;
      bus.y_reload_value <= '0;
      bus.busy           <= 1'b0;
    end else begin
      frame_q        <= bus.frame_clk;
      bus.ts_collide <= 1'b0;
      bus.bs_collide <= 1'b0;
      bus.y_reload   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_rise) begin
            if (active && top_hit) begin
              state              <= TOP_HIT;
              bus.ts_collide     <= 1'b1;
              bus.y_reload       <= 1'b1;
              bus.y_reload_value <= YW'(top_entry);
              bus.busy           <= 1'b1;
            end else if (bs_allowed && bot_hit) begin
              state              <= BOT_HIT;
              bus.bs_collide     <= 1'b1;
              bus.y_reload       <= 1'b1;
              bus.y_reload_value <= YW'(bot_entry);
              bus.busy           <= 1'b1;
            end
          end
        end
        TOP_HIT, BOT_HIT: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (frame_rise) begin
            if ((settle_cnt >= SETTLE_LAST) && !top_hit && !bot_hit) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else if (settle_cnt < SETTLE_MAX) begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screen_transition_detector.sv
// Bench for screen_transition_detector: directed scenarios followed by random
// sprite/screen/frame traffic, every cycle checked against a frame-level model.
module tb_screen_transition_detector;

  localparam int TOP    = 0;
  localparam int BOT    = 479;
  localparam int MARGIN = 8;
  localparam int SF     = 4;

  logic CLK = 1'b0;
  logic reset;

  screen_transition_detector_if bus();

  screen_transition_detector dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int ts_total    = 0;
  int bs_total    = 0;

  // Reference model: "cooldown" is -1 when armed, otherwise the number of
  // frame edges seen since the crossing; "pulse_cycle" marks the pulse cycle.
  bit m_prev;
  bit pulse_cycle;
  int cooldown;
  bit e_ts;
  bit e_bs;
  int e_val;

  function automatic int clampv(input int v);
    if (v < TOP) return TOP;
    if (v > BOT) return BOT;
    return v;
  endfunction

  task automatic model_reset();
    m_prev      = 1'b0;
    pulse_cycle = 1'b0;
    cooldown    = -1;
    e_ts        = 1'b0;
    e_bs        = 1'b0;
    e_val       = 0;
  endtask

  // Predicts what the outputs will show after the coming clock edge
  task automatic model_step();
    int  y;
    int  s;
    bit  rise;
    bit  top;
    bit  bottom;
    bit  playable;
    logic [10:0] bg;
    y        = int'(bus.ball_y);
    s        = int'(bus.ball_size);
    bg       = bus.background_number;
    rise     = bus.frame_clk && !m_prev;
    top      = (y <= TOP + s);
    bottom   = (y + s >= BOT);
    playable = (bg[8:1] != 8'h00);
    e_ts     = 1'b0;
    e_bs     = 1'b0;
    if (pulse_cycle) begin
      pulse_cycle = 1'b0;
      cooldown    = 0;
    end else if (cooldown >= 0) begin
      if (rise) begin
        if (cooldown >= SF - 1 && !top && !bottom) cooldown = -1;
        else cooldown = cooldown + 1;
      end
    end else if (rise) begin
      if (playable && top) begin
        e_ts        = 1'b1;
        pulse_cycle = 1'b1;
        e_val       = clampv(BOT - s - MARGIN);
      end else if (playable && !bg[1] && bottom) begin
        e_bs        = 1'b1;
        pulse_cycle = 1'b1;
        e_val       = clampv(TOP + s + MARGIN);
      end
    end
    m_prev = bus.frame_clk;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit busy_exp;
    busy_exp = pulse_cycle || (cooldown >= 0);
    check({tag, ".ts"},   32'(bus.ts_collide),     32'(e_ts));
    check({tag, ".bs"},   32'(bus.bs_collide),     32'(e_bs));
    check({tag, ".rl"},   32'(bus.y_reload),       32'(e_ts | e_bs));
    check({tag, ".val"},  32'(bus.y_reload_value), 32'(e_val));
    check({tag, ".busy"}, 32'(bus.busy),           32'(busy_exp));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_outputs(tag);
    ts_total += int'(bus.ts_collide);
    bs_total += int'(bus.bs_collide);
  endtask

  // One frame strobe held high for 'hi' cycles, then low for three
  task automatic frame(input string tag, input int hi);
    bus.frame_clk = 1'b1;
    repeat (hi) tick(tag);
    bus.frame_clk = 1'b0;
    repeat (3) tick(tag);
  endtask

  task automatic set_sprite(input logic [10:0] bg, input int y, input int s);
    bus.background_number = bg;
    bus.ball_y            = 10'(y);
    bus.ball_size         = 10'(s);
  endtask

  // Bring the detector back to the armed state with the sprite mid-screen
  task automatic rearm(input string tag);
    bus.ball_y    = 10'd240;
    bus.ball_size = 10'd4;
    repeat (SF + 1) frame(tag, 1);
  endtask

  logic [10:0] bg_pool [13] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                                11'h020, 11'h040, 11'h080, 11'h100, 11'h200,
                                11'h000, 11'h201, 11'h003};

  initial begin
    int ts_before;
    int bs_before;
    int r;

    reset                 = 1'b1;
    bus.frame_clk         = 1'b0;
    bus.ball_y            = '0;
    bus.ball_size         = '0;
    bus.background_number = '0;
    model_reset();
    #12;
    check_outputs("reset");
    reset = 1'b0;
    tick("idle");

    // Green2 top exit: one-cycle pulse, re-entry above bottom zone
    set_sprite(11'h004, 3, 4);
    bus.frame_clk = 1'b1;
    tick("tp1");
    check("tp1_ts", 32'(bus.ts_collide), 32'd1);
    check("tp1_val", 32'(bus.y_reload_value), 32'd467);
    check("tp1_busy", 32'(bus.busy), 32'd1);
    bus.frame_clk = 1'b0;
    tick("tp1b");
    check("tp1_single", 32'(bus.ts_collide), 32'd0);
    check("tp1_val_held", 32'(bus.y_reload_value), 32'd467);

    // Sprite lingers in the top zone: no second crossing
    repeat (10) frame("tp3_hold", 1);
    check("tp3_no_retrigger", 32'(ts_total), 32'd1);
    check("tp3_still_busy", 32'(bus.busy), 32'd1);
    bus.ball_y = 10'd240;
    frame("tp3_leave", 1);
    check("tp3_busy_fall", 32'(bus.busy), 32'd0);

    // Green1 bottom exit is blocked; Gutter1 bottom exit is allowed
    set_sprite(11'h002, 476, 4);
    repeat (3) frame("tp2_green1", 1);
    check("tp2_no_bs", 32'(bs_total), 32'd0);
    check("tp2_idle", 32'(bus.busy), 32'd0);
    bus.background_number = 11'h008;
    bus.frame_clk = 1'b1;
    tick("tp2_gutter");
    check("tp2_bs", 32'(bus.bs_collide), 32'd1);
    check("tp2_val", 32'(bus.y_reload_value), 32'd12);
    bus.frame_clk = 1'b0;
    tick("tp2_gutter");
    rearm("tp2_rearm");

    // Start and end screens never detect
    ts_before = ts_total;
    bs_before = bs_total;
    set_sprite(11'h001, 0, 4);
    repeat (5) frame("tp4_start", 1);
    bus.background_number = 11'h200;
    repeat (5) frame("tp4_end", 1);
    check("tp4_no_ts", 32'(ts_total), 32'(ts_before));
    check("tp4_no_bs", 32'(bs_total), 32'(bs_before));

    // Oversized sprite in both zones: top wins
    set_sprite(11'h040, 240, 300);
    bus.frame_clk = 1'b1;
    tick("tp5");
    check("tp5_ts", 32'(bus.ts_collide), 32'd1);
    check("tp5_no_bs", 32'(bus.bs_collide), 32'd0);
    check("tp5_val", 32'(bus.y_reload_value), 32'd171);
    bus.frame_clk = 1'b0;
    tick("tp5");
    rearm("tp5_rearm");

    // Re-entry clamping at both ends
    set_sprite(11'h004, 100, 500);
    frame("clamp_top", 1);
    check("clamp_top_val", 32'(bus.y_reload_value), 32'd0);
    rearm("clamp_rearm1");
    set_sprite(11'h008, 600, 500);
    frame("clamp_bot", 1);
    check("clamp_bot_val", 32'(bus.y_reload_value), 32'd479);
    rearm("clamp_rearm2");

    // A long frame strobe counts as one edge
    ts_before = ts_total;
    set_sprite(11'h010, 2, 4);
    frame("held_frame", 6);
    check("held_one_pulse", 32'(ts_total), 32'(ts_before + 1));
    rearm("held_rearm");

    // Asynchronous reset during the pulse cycle
    set_sprite(11'h004, 3, 4);
    bus.frame_clk = 1'b1;
    tick("tp6_pre");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("tp6_async");
    @(posedge CLK);
    #1;
    reset = 1'b0;
    bus.frame_clk = 1'b0;
    tick("tp6_post");
    bus.frame_clk = 1'b1;
    tick("tp6_fresh");
    check("tp6_fresh_ts", 32'(bus.ts_collide), 32'd1);
    bus.frame_clk = 1'b0;
    tick("tp6_fresh");

    // Asynchronous reset in the middle of the settle window
    frame("tp6_settle", 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("tp6_async_settle");
    @(posedge CLK);
    #1;
    reset = 1'b0;
    tick("tp6_post2");

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      bus.background_number = bg_pool[$urandom_range(0, 12)];
      r = int'($urandom_range(0, 9));
      if (r < 3)      bus.ball_y = 10'($urandom_range(0, 24));
      else if (r < 6) bus.ball_y = 10'($urandom_range(450, 479));
      else if (r < 9) bus.ball_y = 10'($urandom_range(100, 380));
      else            bus.ball_y = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) bus.ball_size = 10'($urandom_range(0, 1023));
      else                            bus.ball_size = 10'($urandom_range(0, 24));
      bus.frame_clk = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
